// File: rtl/cpu_sequencer.sv
// Multi-cycle control sequencer for a small 8-bit CPU: fetches vectors, opcodes and operands,
// then drives PC, ALU and register-write controls for a subset of 6502-style instructions.
module cpu_sequencer #(
    parameter logic [15:0] RESET_VEC = 16'hFFFC
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [7:0]  i_data,
    input  logic        i_mem_rdy,
    input  logic        i_carry,
    output logic        o_mem_rd,
    output logic [1:0]  o_addr_src,
    output logic        o_sync,
    output logic        o_pc_inc,
    output logic        o_pc_load_en,
    output logic [15:0] o_pc_load_addr,
    output logic [2:0]  o_alu_op_sel,
    output logic [1:0]  o_alu_src_a,
    output logic [1:0]  o_alu_src_b,
    output logic        o_alu_sub,
    output logic        o_alu_dec,
    output logic        o_alu_cin,
    output logic        o_wr_a,
    output logic        o_wr_x,
    output logic        o_wr_y,
    output logic        o_flags_we,
    output logic [7:0]  o_ir,
    output logic [7:0]  o_operand,
    output logic        o_halt
);

    typedef enum logic [2:0] {
        ST_VEC_LO  = 3'd0,
        ST_VEC_HI  = 3'd1,
        ST_FETCH   = 3'd2,
        ST_OPER    = 3'd3,
        ST_OPER_HI = 3'd4,
        ST_EXEC    = 3'd5,
        ST_HALT    = 3'd6
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  ir_q, ir_d;
    logic [7:0]  operand_q, operand_d;
    logic [7:0]  vec_lo_q, vec_lo_d;
    logic        rd_req_s, rd_done_s;

    logic        mem_rd_s, sync_s, pc_inc_s, load_en_s, halt_s;
    logic [1:0]  addr_src_s;
    logic [15:0] load_addr_s;
    logic [2:0]  op_sel_s;
    logic [1:0]  src_a_s, src_b_s;
    logic        sub_s, dec_s, cin_s;
    logic        wr_a_s, wr_x_s, wr_y_s, flags_we_s;

    // Opcode classes: operand-carrying instructions, implied instructions, everything else halts.
    function automatic state_t fetch_target(input logic [7:0] op);
        state_t nxt;
        case (op)
            8'hA9, 8'hA2, 8'hA0, 8'h69, 8'hE9,
            8'h29, 8'h09, 8'h49, 8'h4C:          nxt = ST_OPER;
            8'hAA, 8'hA8, 8'hE8, 8'hCA, 8'hEA:   nxt = ST_EXEC;
            default:                             nxt = ST_HALT;
        endcase
        return nxt;
    endfunction

    assign rd_req_s  = (state_q != ST_EXEC) && (state_q != ST_HALT);
    assign rd_done_s = rd_req_s & i_mem_rdy;

    // Next-state and latch logic; nothing moves until a pending read completes.
    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        operand_d = operand_q;
        vec_lo_d  = vec_lo_q;
        case (state_q)
            ST_VEC_LO: begin
                if (rd_done_s) begin
                    vec_lo_d = i_data;
                    state_d  = ST_VEC_HI;
                end else begin
                    state_d  = state_q;
                end
            end
            ST_VEC_HI: begin
                if (rd_done_s) state_d = ST_FETCH;
                else           state_d = state_q;
            end
            ST_FETCH: begin
                if (rd_done_s) begin
                    ir_d    = i_data;
                    state_d = fetch_target(i_data);
                end else begin
                    state_d = state_q;
                end
            end
            ST_OPER: begin
                if (rd_done_s) begin
                    operand_d = i_data;
                    state_d   = (ir_q == 8'h4C) ? ST_OPER_HI : ST_EXEC;
                end else begin
                    state_d   = state_q;
                end
            end
            ST_OPER_HI: begin
                if (rd_done_s) state_d = ST_FETCH;
                else           state_d = state_q;
            end
            ST_EXEC: state_d = ST_FETCH;
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_VEC_LO;
        endcase
    end

    // Sequencer state and latched bytes, with synchronous reset that may abort any instruction.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q   <= ST_VEC_LO;
            ir_q      <= 8'h00;
            operand_q <= 8'h00;
            vec_lo_q  <= 8'h00;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            operand_q <= operand_d;
            vec_lo_q  <= vec_lo_d;
        end
    end

    // Per-state control decode; PC strobes fire only in the cycle a read completes.
    always_comb begin
        mem_rd_s    = 1'b0;
        addr_src_s  = 2'd0;
        sync_s      = 1'b0;
        pc_inc_s    = 1'b0;
        load_en_s   = 1'b0;
        load_addr_s = RESET_VEC;
        op_sel_s    = 3'd0;
        src_a_s     = 2'd0;
        src_b_s     = 2'd0;
        sub_s       = 1'b0;
        dec_s       = 1'b0;
        cin_s       = 1'b0;
        wr_a_s      = 1'b0;
        wr_x_s      = 1'b0;
        wr_y_s      = 1'b0;
        flags_we_s  = 1'b0;
        halt_s      = 1'b0;
        case (state_q)
            ST_VEC_LO: begin
                mem_rd_s   = 1'b1;
                addr_src_s = 2'd1;
            end
            ST_VEC_HI: begin
                mem_rd_s   = 1'b1;
                addr_src_s = 2'd2;
                load_en_s  = rd_done_s;
                if (rd_done_s) load_addr_s = {i_data, vec_lo_q};
                else           load_addr_s = RESET_VEC;
            end
            ST_FETCH: begin
                mem_rd_s = 1'b1;
                sync_s   = 1'b1;
                pc_inc_s = rd_done_s;
            end
            ST_OPER: begin
                mem_rd_s = 1'b1;
                pc_inc_s = rd_done_s;
            end
            ST_OPER_HI: begin
                mem_rd_s  = 1'b1;
                load_en_s = rd_done_s;
                if (rd_done_s) load_addr_s = {i_data, operand_q};
                else           load_addr_s = RESET_VEC;
            end
            ST_EXEC: begin
                case (ir_q)
                    8'hA9: begin op_sel_s = 3'd4; wr_a_s = 1'b1; flags_we_s = 1'b1; end
                    8'hA2: begin op_sel_s = 3'd4; wr_x_s = 1'b1; flags_we_s = 1'b1; end
                    8'hA0: begin op_sel_s = 3'd4; wr_y_s = 1'b1; flags_we_s = 1'b1; end
                    8'h69: begin cin_s = i_carry; wr_a_s = 1'b1; flags_we_s = 1'b1; end
                    8'hE9: begin cin_s = i_carry; sub_s = 1'b1; wr_a_s = 1'b1; flags_we_s = 1'b1; end
                    8'h29: begin op_sel_s = 3'd1; wr_a_s = 1'b1; flags_we_s = 1'b1; end
                    8'h09: begin op_sel_s = 3'd2; wr_a_s = 1'b1; flags_we_s = 1'b1; end
                    8'h49: begin op_sel_s = 3'd3; wr_a_s = 1'b1; flags_we_s = 1'b1; end
                    8'hAA: begin op_sel_s = 3'd4; src_b_s = 2'd2; wr_x_s = 1'b1; flags_we_s = 1'b1; end
                    8'hA8: begin op_sel_s = 3'd4; src_b_s = 2'd2; wr_y_s = 1'b1; flags_we_s = 1'b1; end
                    8'hE8: begin src_a_s = 2'd1; src_b_s = 2'd1; cin_s = 1'b1; wr_x_s = 1'b1; flags_we_s = 1'b1; end
                    8'hCA: begin src_a_s = 2'd1; src_b_s = 2'd1; dec_s = 1'b1; wr_x_s = 1'b1; flags_we_s = 1'b1; end
                    default: flags_we_s = 1'b0;
                endcase
            end
            ST_HALT: halt_s = 1'b1;
            default: halt_s = 1'b0;
        endcase
    end

    // Bus requests, PC strobes, write strobes and halt are suppressed while reset is held.
    assign o_mem_rd       = i_rst_n & mem_rd_s;
    assign o_pc_inc       = i_rst_n & pc_inc_s;
    assign o_pc_load_en   = i_rst_n & load_en_s;
    assign o_wr_a         = i_rst_n & wr_a_s;
    assign o_wr_x         = i_rst_n & wr_x_s;
    assign o_wr_y         = i_rst_n & wr_y_s;
    assign o_flags_we     = i_rst_n & flags_we_s;
    assign o_halt         = i_rst_n & halt_s;
    assign o_addr_src     = addr_src_s;
    assign o_sync         = sync_s;
    assign o_pc_load_addr = load_addr_s;
    assign o_alu_op_sel   = op_sel_s;
    assign o_alu_src_a    = src_a_s;
    assign o_alu_src_b    = src_b_s;
    assign o_alu_sub      = sub_s;
    assign o_alu_dec      = dec_s;
    assign o_alu_cin      = cin_s;
    assign o_ir           = ir_q;
    assign o_operand      = operand_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: a memory image plus an instruction-level model predicts
// every output each cycle; literal checks pin the key cycles of the reset, LDA, ADC, JMP and halt flows.
module tb_cpu_sequencer;

    localparam logic [15:0] RV = 16'hFFFC;

    logic        i_clk = 1'b0;
    logic        i_rst_n, i_mem_rdy, i_carry;
    logic [7:0]  i_data;
    logic        o_mem_rd, o_sync, o_pc_inc, o_pc_load_en;
    logic [1:0]  o_addr_src, o_alu_src_a, o_alu_src_b;
    logic [15:0] o_pc_load_addr;
    logic [2:0]  o_alu_op_sel;
    logic        o_alu_sub, o_alu_dec, o_alu_cin;
    logic        o_wr_a, o_wr_x, o_wr_y, o_flags_we, o_halt;
    logic [7:0]  o_ir, o_operand;

    always #5 i_clk = ~i_clk;

    cpu_sequencer #(.RESET_VEC(RV)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_data(i_data), .i_mem_rdy(i_mem_rdy),
        .i_carry(i_carry), .o_mem_rd(o_mem_rd), .o_addr_src(o_addr_src), .o_sync(o_sync),
        .o_pc_inc(o_pc_inc), .o_pc_load_en(o_pc_load_en), .o_pc_load_addr(o_pc_load_addr),
        .o_alu_op_sel(o_alu_op_sel), .o_alu_src_a(o_alu_src_a), .o_alu_src_b(o_alu_src_b),
        .o_alu_sub(o_alu_sub), .o_alu_dec(o_alu_dec), .o_alu_cin(o_alu_cin),
        .o_wr_a(o_wr_a), .o_wr_x(o_wr_x), .o_wr_y(o_wr_y), .o_flags_we(o_flags_we),
        .o_ir(o_ir), .o_operand(o_operand), .o_halt(o_halt)
    );

    typedef struct packed {
        logic [2:0] op;
        logic [1:0] sa;
        logic [1:0] sb;
        logic       sub;
        logic       dec;
        logic       cin_carry;
        logic       cin_one;
        logic       wa;
        logic       wx;
        logic       wy;
        logic       fl;
    } alu_exp_t;

    logic [7:0] mem [0:65535];
    int n_vec = 0;
    int n_err = 0;

    // Model: m_seq 0 = vector fetch, 1 = running instructions, 2 = halted; m_step = read/exec index.
    int         m_seq = 0;
    int         m_step = 0;
    bit         m_valid = 1'b0;
    logic [15:0] m_pc = 16'h0000;
    logic [7:0]  m_ir = 8'h00, m_opr = 8'h00, m_vlo = 8'h00;

    logic        s_mem_rd, s_sync, s_pc_inc, s_load_en, s_wr_a, s_wr_x, s_flags, s_halt, s_cin;
    logic [1:0]  s_addr_src, s_sb;
    logic [2:0]  s_op;
    logic [15:0] s_load_addr;
    logic [7:0]  s_ir, s_operand;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // 0 implied, 1 immediate, 2 jump absolute, 3 illegal
    function automatic int cls(input logic [7:0] op);
        case (op)
            8'hAA, 8'hA8, 8'hE8, 8'hCA, 8'hEA:                         return 0;
            8'hA9, 8'hA2, 8'hA0, 8'h69, 8'hE9, 8'h29, 8'h09, 8'h49:    return 1;
            8'h4C:                                                     return 2;
            default:                                                   return 3;
        endcase
    endfunction

    function automatic bit in_exec();
        return (m_seq == 1) && ((m_step == 1 && cls(m_ir) == 0) || (m_step == 2 && cls(m_ir) == 1));
    endfunction

    function automatic alu_exp_t alu_for(input logic [7:0] op);
        alu_exp_t e;
        e = '0;
        case (op)
            8'hA9: begin e.op = 3'd4; e.wa = 1'b1; e.fl = 1'b1; end
            8'hA2: begin e.op = 3'd4; e.wx = 1'b1; e.fl = 1'b1; end
            8'hA0: begin e.op = 3'd4; e.wy = 1'b1; e.fl = 1'b1; end
            8'h69: begin e.cin_carry = 1'b1; e.wa = 1'b1; e.fl = 1'b1; end
            8'hE9: begin e.cin_carry = 1'b1; e.sub = 1'b1; e.wa = 1'b1; e.fl = 1'b1; end
            8'h29: begin e.op = 3'd1; e.wa = 1'b1; e.fl = 1'b1; end
            8'h09: begin e.op = 3'd2; e.wa = 1'b1; e.fl = 1'b1; end
            8'h49: begin e.op = 3'd3; e.wa = 1'b1; e.fl = 1'b1; end
            8'hAA: begin e.op = 3'd4; e.sb = 2'd2; e.wx = 1'b1; e.fl = 1'b1; end
            8'hA8: begin e.op = 3'd4; e.sb = 2'd2; e.wy = 1'b1; e.fl = 1'b1; end
            8'hE8: begin e.sa = 2'd1; e.sb = 2'd1; e.cin_one = 1'b1; e.wx = 1'b1; e.fl = 1'b1; end
            8'hCA: begin e.sa = 2'd1; e.sb = 2'd1; e.dec = 1'b1; e.wx = 1'b1; e.fl = 1'b1; end
            default: e = '0;
        endcase
        return e;
    endfunction

    // One clock: drive inputs at negedge, compare everything against the model, then advance it.
    task automatic cyc(input logic rst, input logic rdy, input logic car);
        logic [15:0] a;
        logic [7:0]  d;
        bit          rd, done, ex, ld;
        alu_exp_t    e;
        @(negedge i_clk);
        a = (m_seq == 0) ? ((m_step == 0) ? RV : RV + 16'd1) : m_pc;
        d = rdy ? mem[a] : 8'hBD;
        i_rst_n = rst; i_mem_rdy = rdy; i_carry = car; i_data = d;
        #1;
        ex   = in_exec();
        rd   = (m_seq == 0) || (m_seq == 1 && !ex);
        done = rd && rdy;
        ld   = done && ((m_seq == 0 && m_step == 1) || (m_seq == 1 && m_step == 2 && cls(m_ir) == 2));
        e    = ex ? alu_for(m_ir) : '0;
        chk("mem_rd",   16'(o_mem_rd),     16'(rst && rd));
        chk("pc_inc",   16'(o_pc_inc),     16'(rst && done && m_seq == 1 && (m_step == 0 || m_step == 1)));
        chk("pc_load",  16'(o_pc_load_en), 16'(rst && ld));
        if (rst && ld) chk("load_addr", o_pc_load_addr, {d, (m_seq == 0) ? m_vlo : m_opr});
        chk("wr_a",     16'(o_wr_a),       16'(rst & e.wa));
        chk("wr_x",     16'(o_wr_x),       16'(rst & e.wx));
        chk("wr_y",     16'(o_wr_y),       16'(rst & e.wy));
        chk("flags_we", 16'(o_flags_we),   16'(rst & e.fl));
        chk("halt",     16'(o_halt),       16'(rst && m_seq == 2));
        if (m_valid) begin
            chk("addr_src", 16'(o_addr_src),   (m_seq == 0) ? 16'(m_step + 1) : 16'd0);
            chk("sync",     16'(o_sync),       16'(m_seq == 1 && m_step == 0));
            chk("op_sel",   16'(o_alu_op_sel), 16'(e.op));
            chk("src_a",    16'(o_alu_src_a),  16'(e.sa));
            chk("src_b",    16'(o_alu_src_b),  16'(e.sb));
            chk("sub",      16'(o_alu_sub),    16'(e.sub));
            chk("dec",      16'(o_alu_dec),    16'(e.dec));
            chk("cin",      16'(o_alu_cin),    16'(e.cin_one | (e.cin_carry & car)));
            chk("ir",       16'(o_ir),         16'(m_ir));
            chk("operand",  16'(o_operand),    16'(m_opr));
        end
        s_mem_rd = o_mem_rd; s_sync = o_sync; s_pc_inc = o_pc_inc; s_load_en = o_pc_load_en;
        s_wr_a = o_wr_a; s_wr_x = o_wr_x; s_flags = o_flags_we; s_halt = o_halt; s_cin = o_alu_cin;
        s_addr_src = o_addr_src; s_sb = o_alu_src_b; s_op = o_alu_op_sel;
        s_load_addr = o_pc_load_addr; s_ir = o_ir; s_operand = o_operand;
        @(posedge i_clk);
        if (!rst) begin
            m_seq = 0; m_step = 0; m_ir = 8'h00; m_opr = 8'h00; m_vlo = 8'h00; m_valid = 1'b1;
        end else if (m_seq == 0) begin
            if (done && m_step == 0) begin
                m_vlo = d; m_step = 1;
            end else if (done) begin
                m_pc = {d, m_vlo}; m_seq = 1; m_step = 0;
            end
        end else if (m_seq == 1) begin
            if (ex) begin
                m_step = 0;
            end else if (done && m_step == 0) begin
                m_ir = d; m_pc = m_pc + 16'd1;
                if (cls(d) == 3) m_seq = 2;
                else             m_step = 1;
            end else if (done && m_step == 1) begin
                m_opr = d; m_pc = m_pc + 16'd1; m_step = 2;
            end else if (done) begin
                m_pc = {d, m_opr}; m_step = 0;
            end
        end
    endtask

    initial begin
        int pulses;
        logic [7:0] prog_main [0:6];
        logic [7:0] prog_sub [0:16];
        prog_main = '{8'hA9, 8'h42, 8'h69, 8'h10, 8'h4C, 8'h34, 8'h12};
        prog_sub  = '{8'hA2, 8'h05, 8'hAA, 8'hA8, 8'hE9, 8'h01, 8'h29, 8'h0F, 8'h09,
                      8'hF0, 8'h49, 8'hFF, 8'hA0, 8'h33, 8'hCA, 8'hEA, 8'hE8};
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'hFFFC] = 8'h00;
        mem[16'hFFFD] = 8'h80;
        for (int i = 0; i < 7; i++)  mem[16'h8000 + i] = prog_main[i];
        for (int i = 0; i < 17; i++) mem[16'h1234 + i] = prog_sub[i];
        i_rst_n = 1'b0; i_mem_rdy = 1'b1; i_carry = 1'b0; i_data = 8'h00;

        // reset, then vector fetch
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        chk("rst_ir", 16'(s_ir), 16'h0000);
        cyc(1'b1, 1'b1, 1'b0);
        chk("vec_lo_rd", 16'(s_mem_rd), 16'h0001);
        chk("vec_lo_src", 16'(s_addr_src), 16'h0001);
        cyc(1'b1, 1'b1, 1'b0);
        chk("vec_hi_load", 16'(s_load_en), 16'h0001);
        chk("vec_hi_addr", s_load_addr, 16'h8000);

        // LDA #42
        cyc(1'b1, 1'b1, 1'b0);
        chk("lda_sync", 16'(s_sync), 16'h0001);
        pulses = int'(s_pc_inc);
        cyc(1'b1, 1'b1, 1'b0);
        pulses += int'(s_pc_inc);
        cyc(1'b1, 1'b1, 1'b0);
        pulses += int'(s_pc_inc);
        chk("lda_pulses", 16'(pulses), 16'd2);
        chk("lda_op", 16'(s_op), 16'd4);
        chk("lda_srcb", 16'(s_sb), 16'd0);
        chk("lda_operand", 16'(s_operand), 16'h0042);
        chk("lda_wr_a", 16'(s_wr_a), 16'd1);
        chk("lda_flags", 16'(s_flags), 16'd1);

        // ADC #10 with two wait states in the operand read
        cyc(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) begin
            cyc(1'b1, 1'b0, 1'b0);
            chk("adc_stall_inc", 16'(s_pc_inc), 16'd0);
            chk("adc_stall_opr", 16'(s_operand), 16'h0042);
        end
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b1);
        chk("adc_operand", 16'(s_operand), 16'h0010);
        chk("adc_cin", 16'(s_cin), 16'd1);

        // JMP $1234
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        chk("jmp_load", 16'(s_load_en), 16'd1);
        chk("jmp_addr", s_load_addr, 16'h1234);
        chk("jmp_no_inc", 16'(s_pc_inc), 16'd0);
        cyc(1'b1, 1'b1, 1'b0);
        chk("jmp_fetch", 16'(s_sync), 16'd1);

        // remaining opcodes with a wait-state pattern until the INX execute cycle
        for (int i = 0; i < 200 && !(in_exec() && m_ir == 8'hE8); i++)
            cyc(1'b1, 1'((i % 5) != 3), 1'(i[0]));
        n_vec++;
        if (!(in_exec() && m_ir == 8'hE8)) begin
            n_err++;
            $display("FAIL reach_inx: INX execute not reached within budget");
        end

        // reset during INX execute; new vector points at an illegal opcode
        mem[16'hFFFD] = 8'h30;
        mem[16'h3000] = 8'h02;
        cyc(1'b0, 1'b1, 1'b1);
        chk("inx_rst_wr_x", 16'(s_wr_x), 16'd0);
        cyc(1'b1, 1'b1, 1'b0);
        chk("post_rst_ir", 16'(s_ir), 16'h0000);
        chk("post_rst_rd", 16'(s_mem_rd), 16'd1);
        chk("post_rst_src", 16'(s_addr_src), 16'd1);
        for (int i = 0; i < 20 && m_seq != 2; i++) cyc(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 1'b1, 1'b0);
            chk("halt_hold", 16'(s_halt), 16'd1);
            chk("halt_no_rd", 16'(s_mem_rd), 16'd0);
        end
        cyc(1'b0, 1'b1, 1'b0);
        chk("halt_rst", 16'(s_halt), 16'd0);
        cyc(1'b1, 1'b1, 1'b0);
        chk("halt_exit_src", 16'(s_addr_src), 16'd1);
        chk("halt_exit_rd", 16'(s_mem_rd), 16'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 SHALL have parameter RESET_VEC, default 16'hFFFC, giving the reset vector low-byte address; the high byte is read from RESET_VEC+1.
REQ-002 SHALL have port i_clk, input, 1, the single clock; all state changes occur on its rising edge.
REQ-003 SHALL have port i_rst_n, input, 1, reset; synchronous, active-low.
REQ-004 SHALL have port i_data, input, 8, memory read data, valid in any cycle where o_mem_rd and i_mem_rdy are both high.
REQ-005 SHALL have port i_mem_rdy, input, 1, memory ready; low inserts wait states.
REQ-006 SHALL have port i_carry, input, 1, carry flag from the datapath.
REQ-007 SHALL have port o_mem_rd, output, 1, memory read request.
REQ-008 SHALL have port o_addr_src, output, 2: 0 = PC, 1 = RESET_VEC, 2 = RESET_VEC+1.
REQ-009 SHALL have port o_sync, output, 1, high during opcode-fetch cycles.
REQ-010 SHALL have ports o_pc_inc (1), o_pc_load_en (1) and o_pc_load_addr (16), outputs, the PC controls.
REQ-011 SHALL have ports o_alu_op_sel (3), o_alu_src_a (2), o_alu_src_b (2), o_alu_sub (1), o_alu_dec (1) and o_alu_cin (1), outputs, the ALU controls.
REQ-012 SHALL have ports o_wr_a, o_wr_x, o_wr_y and o_flags_we, outputs, 1 each, the register write strobes.
REQ-013 SHALL have ports o_ir (8) and o_operand (8), outputs, the latched opcode and operand.
REQ-014 SHALL have port o_halt, output, 1, illegal-opcode halt indicator.

Function
REQ-015 SHALL implement states VEC_LO, VEC_HI, FETCH, OPER, OPER_HI, EXEC and HALT.
REQ-016 A read SHALL complete only when o_mem_rd=1 and i_mem_rdy=1; otherwise the state, latches and all outputs SHALL hold, and o_pc_inc and o_pc_load_en SHALL be 0.
REQ-017 VEC_LO SHALL set o_addr_src=1 and o_mem_rd=1; on completion it SHALL latch i_data as the low byte and go to VEC_HI.
REQ-018 VEC_HI SHALL set o_addr_src=2 and o_mem_rd=1; on completion it SHALL assert o_pc_load_en with o_pc_load_addr={i_data, low byte} and go to FETCH.
REQ-019 FETCH SHALL set o_addr_src=0, o_mem_rd=1 and o_sync=1; on completion it SHALL latch o_ir<=i_data and assert o_pc_inc.
REQ-020 From FETCH, the next state SHALL be OPER for A9, A2, A0, 69, E9, 29, 09, 49 and 4C; EXEC for AA, A8, E8, CA and EA; HALT for any other opcode.
REQ-021 OPER SHALL read at the PC; on completion it SHALL latch o_operand, assert o_pc_inc, and go to OPER_HI if IR=4C, otherwise to EXEC.
REQ-022 OPER_HI SHALL read at the PC; on completion it SHALL assert o_pc_load_en with {i_data, o_operand} and go to FETCH; o_pc_inc SHALL be 0 in this cycle.
REQ-023 EXEC SHALL last exactly one cycle with o_mem_rd=0, drive the ALU controls and strobes per REQ-024/025, then go to FETCH.
REQ-024 Encodings SHALL be: op_sel 0=ADD, 1=AND, 2=OR, 3=EOR, 4=PASS_B; src_a 0=A, 1=X, 2=Y; src_b 0=operand, 1=zero, 2=A.
REQ-025 EXEC mapping SHALL be:
- A9/A2/A0: PASS_B, src_b operand, wr_a/wr_x/wr_y respectively.
- 69: ADD, A, operand, cin=i_carry, wr_a.
- E9: same as 69 plus sub=1.
- 29/09/49: AND/OR/EOR, A, operand, wr_a.
- AA/A8: PASS_B, src_b A, wr_x/wr_y.
- E8: ADD, X, zero, cin=1, wr_x.
- CA: ADD, X, zero, dec=1, wr_x.
- EA: no strobes.
REQ-026 o_flags_we SHALL be 1 in EXEC for every opcode except EA; all strobes SHALL be 0 outside EXEC.
REQ-027 ALU controls outside EXEC SHALL be 0.
REQ-028 Latency with zero wait states SHALL be: implied 2 cycles, immediate 3 cycles, JMP 3 cycles, reset-to-first-FETCH 2 cycles.
REQ-029 HALT SHALL hold o_halt=1 with all read requests and strobes 0 until reset.
REQ-030 PC arithmetic wrap (FFFF+1) is owned by pc_control; the sequencer SHALL only issue o_pc_inc.

Reset
REQ-031 On a rising edge with i_rst_n=0, the state SHALL become VEC_LO and o_ir, o_operand and the vector low byte SHALL become 8'h00, including mid-instruction.
REQ-032 While i_rst_n=0, o_mem_rd, o_pc_inc, o_pc_load_en, all write strobes and o_halt SHALL be forced to 0 combinationally.
REQ-033 In the first cycle after release, outputs SHALL show VEC_LO (o_mem_rd=1, o_addr_src=1).

Verification
REQ-034 Reset with FFFC=00, FFFD=80 and rdy=1 -> VEC_LO, then VEC_HI with o_pc_load_en=1 and load_addr=8000, then o_sync=1.
REQ-035 Fetch A9 42 -> 3 cycles; 2 o_pc_inc pulses; EXEC shows op_sel=4, src_b=0, o_operand=42, o_wr_a=1, o_flags_we=1.
REQ-036 Fetch 69 10 with rdy low for 2 cycles in OPER -> state and outputs held, no pc_inc during the stall; operand=10 latched on the rdy cycle; EXEC shows cin=i_carry.
REQ-037 Fetch 4C 34 12 -> OPER_HI asserts o_pc_load_en with 1234 and no pc_inc; the next cycle is FETCH.
REQ-038 Fetch 02 -> HALT with o_halt=1 persistent and o_mem_rd=0; a reset pulse returns to VEC_LO.
REQ-039 i_rst_n low during the EXEC of E8 -> o_wr_x=0 that cycle; the next state is VEC_LO with o_ir=00.
